// File: rtl/board_ram_arbiter_pkg.sv
// Shared constants for the board RAM arbiter: geometry, cell bit layout, FSM states.
// Cell layout matches the LED side: bit1 red, bit0 green.
package board_ram_arbiter_pkg;
  localparam int unsigned SCAN_LEN  = 8;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned DATA_W    = 2;
  localparam int unsigned ROW_W     = 3;
  localparam int unsigned RED_BIT   = 1;
  localparam int unsigned GREEN_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;
endpackage

// File: rtl/board_ram_arbiter.sv
// Single-port board RAM arbiter: LED row bursts versus game-logic cell accesses.
// Optional macro BOARD_ARB_CLIENT_FAIR_EN reserves the cycle after a burst for a waiting client.
module board_ram_arbiter #(
  parameter int unsigned SCAN_LEN = board_ram_arbiter_pkg::SCAN_LEN,
  parameter int unsigned ADDR_W   = board_ram_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W   = board_ram_arbiter_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n_,
  input  logic              scan_req,
  input  logic [2:0]        scan_row,
  output logic              scan_valid,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_last,
  output logic              scan_overrun,
  input  logic              cli_req,
  input  logic              cli_we,
  input  logic [ADDR_W-1:0] cli_addr,
  input  logic [DATA_W-1:0] cli_wdata,
  output logic              cli_gnt,
  output logic [DATA_W-1:0] cli_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  import board_ram_arbiter_pkg::*;

  localparam int unsigned COL_W = $clog2(SCAN_LEN);

  state_t           state;
  logic [2:0]       row;
  logic [2:0]       pend_row;
  logic [COL_W-1:0] col;
  logic             pending;
  logic             start;
  logic             burst_end;
  logic             cli_serve;
  logic             fair_hold;

`ifdef BOARD_ARB_CLIENT_FAIR_EN
  logic cli_seen;
  logic reserve;

  assign fair_hold = cli_seen || cli_req;
  assign start     = (state == IDLE) && !reserve && (scan_req || pending);

  // Remember client demand seen during a burst; the following IDLE cycle is then theirs.
  always_ff @(posedge clk or negedge rst_n_) begin
    if (!rst_n_) begin
      cli_seen <= 1'b0;
      reserve  <= 1'b0;
    end else begin
      if (burst_end) cli_seen <= 1'b0;
      else if (state == SCAN && cli_req) cli_seen <= 1'b1;
      if (burst_end && fair_hold) reserve <= 1'b1;
      else if (state == IDLE) reserve <= 1'b0;
    end
  end
`else
  assign fair_hold = 1'b0;
  assign start     = (state == IDLE) && (scan_req || pending);
`endif

  assign burst_end = (state == SCAN) && (col == COL_W'(SCAN_LEN - 1));
  assign cli_serve = (state == IDLE) && !start && cli_req && !cli_gnt;

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (state == SCAN) begin
      ram_addr = {row, col};
    end else if (cli_serve) begin
      ram_addr  = cli_addr;
      ram_we    = cli_we;
      ram_wdata = cli_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n_) begin
    if (!rst_n_) begin
      state        <= IDLE;
      row          <= '0;
      pend_row     <= '0;
      col          <= '0;
      pending      <= 1'b0;
      scan_valid   <= 1'b0;
      scan_data    <= '0;
      scan_last    <= 1'b0;
      scan_overrun <= 1'b0;
      cli_gnt      <= 1'b0;
      cli_rdata    <= '0;
    end else begin
      scan_valid <= (state == SCAN);
      scan_data  <= (state == SCAN) ? ram_rdata : '0;
      scan_last  <= burst_end;
      cli_gnt    <= cli_serve;
      cli_rdata  <= (cli_serve && !cli_we) ? ram_rdata : '0;

      // Requests not consumed by a start queue one deep; a second one is dropped.
      if (scan_req && !start) begin
        if (pending) begin
          scan_overrun <= 1'b1;
        end else begin
          pending  <= 1'b1;
          pend_row <= scan_row;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state   <= SCAN;
            row     <= scan_req ? scan_row : pend_row;
            pending <= 1'b0;
            col     <= '0;
          end
        end
        SCAN: begin
          col <= burst_end ? '0 : col + 1'b1;
          if (burst_end) begin
            if (fair_hold) begin
              state <= IDLE;
            end else if (pending) begin
              row     <= pend_row;
              pending <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
